// File: rtl/frame_buf_multi_if.sv
// Handshake and status bundle between the frame buffer controller and its
// writer, reader and memory ports.
interface frame_buf_multi_if #(
  parameter int unsigned ADDR_WIDTH = 29
);
  logic                  wr_req;
  logic                  wr_rdy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_req;
  logic                  rd_rdy;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [3:0]            frame_cnt;
  logic                  full;
  logic                  empty;
  logic                  wr_frame_done;
  logic                  rd_frame_done;
  logic                  frame_dropped;

  modport master (
    input  wr_req, wr_rdy, rd_req, rd_rdy,
    output wr_en, wr_addr, rd_en, rd_addr, frame_cnt, full, empty,
           wr_frame_done, rd_frame_done, frame_dropped
  );

  modport slave (
    output wr_req, wr_rdy, rd_req, rd_rdy,
    input  wr_en, wr_addr, rd_en, rd_addr, frame_cnt, full, empty,
           wr_frame_done, rd_frame_done, frame_dropped
  );
endinterface

// File: rtl/frame_buf_multi.sv
// Multi-slot frame buffer address controller: one writer and one reader walk
// NUM_FRAMES fixed-size slots in a ring, optionally reclaiming the oldest frame.
module frame_buf_multi #(
  parameter int unsigned ADDR_WIDTH  = 29,
  parameter int unsigned BASE_ADDR   = 2,
  parameter int unsigned FRAME_SIZE  = 230400,
  parameter int unsigned NUM_FRAMES  = 3,
  parameter int unsigned DROP_OLDEST = 0
) (
  input  logic                 wr_clk,
  input  logic                 reset,
  frame_buf_multi_if.master    bus
);

  localparam int unsigned OFF_W = (FRAME_SIZE > 2) ? $clog2(FRAME_SIZE) : 1;
  localparam longint unsigned LAST_ADDR =
      longint'(BASE_ADDR) + longint'(NUM_FRAMES) * longint'(FRAME_SIZE) - 1;

  if (FRAME_SIZE < 2) begin : g_bad_frame_size
    $error("frame_buf_multi: FRAME_SIZE must be at least 2");
  end
  if (NUM_FRAMES < 2 || NUM_FRAMES > 8) begin : g_bad_num_frames
    $error("frame_buf_multi: NUM_FRAMES must be in 2..8");
  end
  if (ADDR_WIDTH < 64 && (LAST_ADDR >> ADDR_WIDTH) != 0) begin : g_addr_overflow
    $error("frame_buf_multi: last slot address does not fit ADDR_WIDTH");
  end

  localparam logic [OFF_W-1:0]      OFF_LAST   = OFF_W'(FRAME_SIZE - 1);
  localparam logic [2:0]            SLOT_LAST  = 3'(NUM_FRAMES - 1);
  localparam logic [3:0]            CNT_MAX    = 4'(NUM_FRAMES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FRAME = ADDR_WIDTH'(FRAME_SIZE);

  localparam logic W_IDLE = 1'b0;
  localparam logic W_FILL = 1'b1;
  localparam logic R_IDLE = 1'b0;
  localparam logic R_READ = 1'b1;

  logic                  wr_st_q, wr_st_d;
  logic                  rd_st_q, rd_st_d;
  logic [OFF_W-1:0]      wr_off_q, wr_off_d;
  logic [OFF_W-1:0]      rd_off_q, rd_off_d;
  logic [2:0]            wr_slot_q, wr_slot_d;
  logic [2:0]            rd_slot_q, rd_slot_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;
  logic                  dropped_q, dropped_d;

  logic full, empty, reclaim, wr_en, rd_en;
  logic wr_acc, rd_acc, wr_last, rd_last, reclaim_beat;

  always_comb begin
    full         = (cnt_q == CNT_MAX);
    empty        = (cnt_q == 4'd0);
    reclaim      = (DROP_OLDEST != 0) && full && (rd_st_q == R_IDLE);
    wr_en        = bus.wr_req && ((wr_st_q == W_FILL) || (cnt_q < CNT_MAX) || reclaim);
    wr_acc       = wr_en && bus.wr_rdy;
    reclaim_beat = wr_acc && reclaim && (wr_st_q == W_IDLE);
    // The slot being reclaimed must not start a read in the same cycle.
    rd_en        = bus.rd_req && ((rd_st_q == R_READ) || !empty) && !reclaim_beat;
    rd_acc       = rd_en && bus.rd_rdy;
    wr_last      = wr_acc && (wr_off_q == OFF_LAST);
    rd_last      = rd_acc && (rd_off_q == OFF_LAST);
  end

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_off_d  = wr_off_q;
    wr_slot_d = wr_slot_q;
    wr_addr_d = wr_addr_q;
    rd_st_d   = rd_st_q;
    rd_off_d  = rd_off_q;
    rd_slot_d = rd_slot_q;
    rd_addr_d = rd_addr_q;

    // Slot bases are contiguous, so the next base is the last address plus one.
    if (wr_last) begin
      wr_st_d   = W_IDLE;
      wr_off_d  = '0;
      wr_slot_d = (wr_slot_q == SLOT_LAST) ? 3'd0 : wr_slot_q + 3'd1;
      wr_addr_d = (wr_slot_q == SLOT_LAST) ? ADDR_BASE : wr_addr_q + 1'b1;
    end else if (wr_acc) begin
      wr_st_d   = W_FILL;
      wr_off_d  = wr_off_q + 1'b1;
      wr_addr_d = wr_addr_q + 1'b1;
    end

    if (rd_last) begin
      rd_st_d   = R_IDLE;
      rd_off_d  = '0;
      rd_slot_d = (rd_slot_q == SLOT_LAST) ? 3'd0 : rd_slot_q + 3'd1;
      rd_addr_d = (rd_slot_q == SLOT_LAST) ? ADDR_BASE : rd_addr_q + 1'b1;
    end else if (rd_acc) begin
      rd_st_d   = R_READ;
      rd_off_d  = rd_off_q + 1'b1;
      rd_addr_d = rd_addr_q + 1'b1;
    end else if (reclaim_beat) begin
      rd_slot_d = (rd_slot_q == SLOT_LAST) ? 3'd0 : rd_slot_q + 3'd1;
      rd_addr_d = (rd_slot_q == SLOT_LAST) ? ADDR_BASE : rd_addr_q + ADDR_FRAME;
    end

    cnt_d     = cnt_q + {3'b0, wr_last} - {3'b0, rd_last} - {3'b0, reclaim_beat};
    wr_done_d = wr_last;
    rd_done_d = rd_last;
    dropped_d = reclaim_beat;
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wr_st_q   <= W_IDLE;
      rd_st_q   <= R_IDLE;
      wr_off_q  <= '0;
      rd_off_q  <= '0;
      wr_slot_q <= 3'd0;
      rd_slot_q <= 3'd0;
      cnt_q     <= 4'd0;
      wr_addr_q <= ADDR_BASE;
      rd_addr_q <= ADDR_BASE;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      wr_st_q   <= wr_st_d;
      rd_st_q   <= rd_st_d;
      wr_off_q  <= wr_off_d;
      rd_off_q  <= rd_off_d;
      wr_slot_q <= wr_slot_d;
      rd_slot_q <= rd_slot_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.wr_en         = wr_en;
  assign bus.rd_en         = rd_en;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.frame_cnt     = cnt_q;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.wr_frame_done = wr_done_q;
  assign bus.rd_frame_done = rd_done_q;
  assign bus.frame_dropped = dropped_q;

endmodule

// File: tb/tb_frame_buf_multi.sv
// Random and directed stimulus for two frame_buf_multi instances (stalling and
// drop-oldest), compared each cycle against a frame-level reference model.
module tb_frame_buf_multi;
  localparam int unsigned AW   = 16;
  localparam int unsigned BASE = 2;
  localparam int unsigned FS   = 4;
  localparam int unsigned NF   = 2;

  logic wr_clk = 1'b0;
  logic reset;
  always #5 wr_clk = ~wr_clk;

  frame_buf_multi_if #(.ADDR_WIDTH(AW)) bus0 ();
  frame_buf_multi_if #(.ADDR_WIDTH(AW)) bus1 ();

  frame_buf_multi #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_SIZE(FS), .NUM_FRAMES(NF), .DROP_OLDEST(0)
  ) u_dut_stall (
    .wr_clk(wr_clk), .reset(reset), .bus(bus0)
  );

  frame_buf_multi #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_SIZE(FS), .NUM_FRAMES(NF), .DROP_OLDEST(1)
  ) u_dut_drop (
    .wr_clk(wr_clk), .reset(reset), .bus(bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: committed unread frames, slot indices and word offsets.
  int m_cnt[2], m_wslot[2], m_rslot[2], m_woff[2], m_roff[2];
  bit m_wd[2], m_rd[2], m_dr[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_wslot[m] = 0; m_rslot[m] = 0; m_woff[m] = 0; m_roff[m] = 0;
      m_wd[m] = 0; m_rd[m] = 0; m_dr[m] = 0;
    end
  endtask

  task automatic step(input bit rst, input bit wreq, input bit wrdy,
                      input bit rreq, input bit rrdy);
    logic          o_we[2], o_re[2], o_full[2], o_empty[2], o_wd[2], o_rd[2], o_dr[2];
    logic [AW-1:0] o_wa[2], o_ra[2];
    logic [3:0]    o_cnt[2];
    @(negedge wr_clk);
    reset = rst;
    bus0.wr_req = wreq; bus0.wr_rdy = wrdy; bus0.rd_req = rreq; bus0.rd_rdy = rrdy;
    bus1.wr_req = wreq; bus1.wr_rdy = wrdy; bus1.rd_req = rreq; bus1.rd_rdy = rrdy;
    #1;
    o_we[0] = bus0.wr_en; o_re[0] = bus0.rd_en; o_wa[0] = bus0.wr_addr;
    o_ra[0] = bus0.rd_addr; o_cnt[0] = bus0.frame_cnt; o_full[0] = bus0.full;
    o_empty[0] = bus0.empty; o_wd[0] = bus0.wr_frame_done;
    o_rd[0] = bus0.rd_frame_done; o_dr[0] = bus0.frame_dropped;
    o_we[1] = bus1.wr_en; o_re[1] = bus1.rd_en; o_wa[1] = bus1.wr_addr;
    o_ra[1] = bus1.rd_addr; o_cnt[1] = bus1.frame_cnt; o_full[1] = bus1.full;
    o_empty[1] = bus1.empty; o_wd[1] = bus1.wr_frame_done;
    o_rd[1] = bus1.rd_frame_done; o_dr[1] = bus1.frame_dropped;
    for (int m = 0; m < 2; m++) begin
      bit    reclaim, e_we, w_acc, rc, e_re, r_acc, wl, rl;
      string sfx;
      sfx     = (m == 0) ? "stall" : "drop";
      reclaim = (m == 1) && (m_cnt[m] == NF) && (m_roff[m] == 0);
      e_we    = wreq && (m_woff[m] > 0 || m_cnt[m] < NF || reclaim);
      w_acc   = e_we && wrdy;
      rc      = w_acc && reclaim && (m_woff[m] == 0);
      e_re    = rreq && (m_roff[m] > 0 || m_cnt[m] > 0) && !rc;
      r_acc   = e_re && rrdy;
      check({"wr_en/", sfx}, 32'(o_we[m]), 32'(e_we));
      check({"rd_en/", sfx}, 32'(o_re[m]), 32'(e_re));
      check({"wr_addr/", sfx}, 32'(o_wa[m]), BASE + m_wslot[m] * FS + m_woff[m]);
      check({"rd_addr/", sfx}, 32'(o_ra[m]), BASE + m_rslot[m] * FS + m_roff[m]);
      check({"frame_cnt/", sfx}, 32'(o_cnt[m]), m_cnt[m]);
      check({"full/", sfx}, 32'(o_full[m]), 32'(m_cnt[m] == NF));
      check({"empty/", sfx}, 32'(o_empty[m]), 32'(m_cnt[m] == 0));
      check({"wr_frame_done/", sfx}, 32'(o_wd[m]), 32'(m_wd[m]));
      check({"rd_frame_done/", sfx}, 32'(o_rd[m]), 32'(m_rd[m]));
      check({"frame_dropped/", sfx}, 32'(o_dr[m]), 32'(m_dr[m]));
      if (!rst) begin
        wl = w_acc && (m_woff[m] == FS - 1);
        rl = r_acc && (m_roff[m] == FS - 1);
        if (w_acc) m_woff[m] = wl ? 0 : m_woff[m] + 1;
        if (wl) m_wslot[m] = (m_wslot[m] + 1) % NF;
        if (r_acc) m_roff[m] = rl ? 0 : m_roff[m] + 1;
        if (rl || rc) m_rslot[m] = (m_rslot[m] + 1) % NF;
        m_cnt[m] = m_cnt[m] + int'(wl) - int'(rl) - int'(rc);
        m_wd[m] = wl; m_rd[m] = rl; m_dr[m] = rc;
      end
    end
    if (rst) model_reset();
  endtask

  initial begin
    int rd_pct;
    reset = 1'b1;
    bus0.wr_req = 0; bus0.wr_rdy = 0; bus0.rd_req = 0; bus0.rd_rdy = 0;
    bus1.wr_req = 0; bus1.wr_rdy = 0; bus1.rd_req = 0; bus1.rd_rdy = 0;
    model_reset();
    repeat (2) @(posedge wr_clk);

    // Reset with a pending read request.
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check("rst wr_addr", 32'(bus0.wr_addr), 2);
    check("rst rd_addr", 32'(bus0.rd_addr), 2);
    check("rst empty", 32'(bus0.empty), 1);
    check("rst rd_en", 32'(bus0.rd_en), 0);

    // First frame with a memory stall mid-frame.
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (3) begin
      step(0, 1, 0, 0, 0);
      check("stall wr_en", 32'(bus0.wr_en), 1);
      check("stall wr_addr", 32'(bus0.wr_addr), 4);
    end
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    check("frame1 wr_frame_done", 32'(bus0.wr_frame_done), 1);
    check("frame1 frame_cnt", 32'(bus0.frame_cnt), 1);
    check("frame1 wr_addr", 32'(bus0.wr_addr), 6);
    check("frame1 rd_en", 32'(bus0.rd_en), 1);
    check("frame1 rd_addr", 32'(bus0.rd_addr), 2);

    // Second frame fills both slots.
    repeat (4) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    check("full stall full", 32'(bus0.full), 1);
    check("full stall wr_en", 32'(bus0.wr_en), 0);
    check("full stall wr_addr", 32'(bus0.wr_addr), 2);
    check("full drop wr_en", 32'(bus1.wr_en), 1);
    step(0, 0, 0, 0, 0);
    check("drop pulse", 32'(bus1.frame_dropped), 1);
    check("drop rd_addr", 32'(bus1.rd_addr), 6);
    check("drop frame_cnt", 32'(bus1.frame_cnt), 1);

    // Random traffic with alternating reader pressure and occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rd_pct = ((cyc / 120) % 2 == 1) ? 85 : 15;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < rd_pct,
           $urandom_range(0, 99) < 75);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
